// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide front end: funct3 codes,
// controller states and core mode encoding.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIX,
    ST_DONE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/muldiv_ctrl_muldiv.sv
// Iterative unsigned 32x32 multiply / 32/32 divide core. One bit per cycle;
// ready pulses 33 cycles after an accepted valid, out holds until the next op.
module Muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic [63:0] out
);

  logic        busy;
  logic        mode_r;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] opb;
  logic [32:0] shifted;
  logic [63:0] div_next;

  // Restoring division step: acc holds {remainder, dividend/quotient}
  always_comb begin
    shifted = {acc[63:32], acc[31]};
    if (shifted >= {1'b0, opb}) begin
      div_next = {32'(shifted - {1'b0, opb}), acc[30:0], 1'b1};
    end else begin
      div_next = {shifted[31:0], acc[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      ready  <= 1'b0;
      mode_r <= MODE_MUL;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      opb    <= 32'd0;
    end else begin
      ready <= 1'b0;
      if (!busy) begin
        if (valid) begin
          busy   <= 1'b1;
          cnt    <= 6'd32;
          mode_r <= mode;
          opb    <= b;
          mcand  <= {32'd0, a};
          acc    <= (mode == MODE_DIV) ? {32'd0, a} : 64'd0;
        end
      end else begin
        if (mode_r == MODE_DIV) begin
          acc <= div_next;
        end else begin
          if (opb[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
        end
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      end
    end
  end

  assign out = acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M front-end: decodes funct3, feeds magnitudes to the unsigned Muldiv
// core, sign-corrects the result and stalls EX until it is ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req; special cases resolved here directly
// ISSUE    | one-cycle valid to the core with registered magnitudes
// WAIT     | core busy, waiting for ready
// FIX      | sign correction and result select
// DONE     | done pulse, pipeline advances
// DRAIN    | flushed while core busy; discard its result
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  state_t      state;
  logic [31:0] op_a, op_b;
  logic        mode, neg, done_r;
  logic [2:0]  op;
  logic [63:0] prod;
  logic        core_valid, core_ready;
  logic [63:0] core_out;

  logic        a_signed, b_signed, sign_a, sign_b, neg_in;
  logic        div_zero, div_ovf;
  logic [31:0] abs_a, abs_b, special;
  logic [31:0] neg_hi, quo_neg, rem_neg, fix_res;

  always_comb begin
    a_signed = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
               (funct3 == F3_DIV)  | (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);
    sign_a   = a_signed & rs1[31];
    sign_b   = b_signed & rs2[31];
    abs_a    = sign_a ? (~rs1 + 32'd1) : rs1;
    abs_b    = sign_b ? (~rs2 + 32'd1) : rs2;
    // Remainder and MULHSU follow the dividend/rs1 sign only
    neg_in   = ((funct3 == F3_REM) | (funct3 == F3_MULHSU)) ? sign_a : (sign_a ^ sign_b);
    div_zero = funct3[2] & (rs2 == 32'd0);
    div_ovf  = ((funct3 == F3_DIV) | (funct3 == F3_REM)) &
               (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    special  = 32'd0;
    if (div_zero)     special = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else if (div_ovf) special = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    neg_hi  = ~prod[63:32] + {31'd0, prod[31:0] == 32'd0};
    quo_neg = ~prod[31:0] + 32'd1;
    rem_neg = ~prod[63:32] + 32'd1;
    case (op)
      F3_MUL:                       fix_res = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = neg ? neg_hi : prod[63:32];
      F3_DIV, F3_DIVU:              fix_res = neg ? quo_neg : prod[31:0];
      default:                      fix_res = neg ? rem_neg : prod[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_r <= 1'b0;
      result <= 32'd0;
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      mode   <= MODE_MUL;
      neg    <= 1'b0;
      op     <= F3_MUL;
      prod   <= 64'd0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && !flush) begin
            if (div_zero || div_ovf) begin
              result <= special;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end else begin
              op_a  <= abs_a;
              op_b  <= abs_b;
              mode  <= funct3[2] ? MODE_DIV : MODE_MUL;
              neg   <= neg_in;
              op    <= funct3;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= flush ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          if (flush) begin
            state <= core_ready ? ST_IDLE : ST_DRAIN;
          end else if (core_ready) begin
            prod  <= core_out;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            result <= fix_res;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_DRAIN: if (core_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A flush landing on the DONE cycle kills the pulse
  assign done       = done_r & ~flush;
  assign core_valid = (state == ST_ISSUE) & ~flush;
  assign stall      = (req & ~done) | ((state == ST_DRAIN) & req);

  Muldiv core (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (core_valid),
    .mode  (mode),
    .a     (op_a),
    .b     (op_b),
    .ready (core_ready),
    .out   (core_out)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M cases, randomized
// back-to-back ops against an arithmetic model, flush and mid-op reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

  localparam int NORMAL_LAT = 36;
  localparam int CORE_LAT   = 33;

  muldiv_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Architectural RV32M result computed with plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Presents one op at the next negedge and follows it to done (bounded).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output int stall_err, output int vcount);
    @(negedge clk);
    req = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    lat = -1; stall_err = 0; vcount = 0; res = 32'hDEAD_BEEF;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (dut.core_valid) vcount++;
      if (done) begin
        lat = k; res = result;
        if (stall) stall_err++;
        break;
      end
      if (!stall) stall_err++;
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    rst_n = 1'b1;
  endtask

  logic [2:0]  d_f3  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int          d_lat [12] = '{36, 36, 36, 36, 36, 36, 36, 36, 1, 1, 1, 1};

  task automatic test_directed();
    logic [31:0] res;
    int lat, serr, vc;
    for (int i = 0; i < 12; i++) begin
      do_op(d_f3[i], d_a[i], d_b[i], res, lat, serr, vc);
      vectors++; if (res !== d_exp[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, d_exp[i]); end
      vectors++; if (lat != d_lat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, d_lat[i]); end
      vectors++; if (serr != 0) begin errors++; $display("FAIL dir%0d_stall got %0d bad cycles want 0", i, serr); end
      vectors++; if (vc != ((d_lat[i] == 1) ? 0 : 1)) begin errors++; $display("FAIL dir%0d_core_valid got %0d want %0d", i, vc, (d_lat[i] == 1) ? 0 : 1); end
    end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] res, a, b, exp;
    logic [2:0]  f3;
    int lat, serr, vc, exp_lat;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      exp = model(f3, a, b);
      exp_lat = is_special(f3, a, b) ? 1 : NORMAL_LAT;
      do_op(f3, a, b, res, lat, serr, vc);
      vectors++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, res, exp); end
      vectors++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat); end
      vectors++; if (serr != 0) begin errors++; $display("FAIL rnd%0d_stall got %0d bad cycles want 0", i, serr); end
    end
  endtask

  task automatic test_flush_wait();
    int lat, serr, early;
    // killed op accepted at T; flush on WAIT cycle 10 (T+11)
    localparam int FLUSH_AT = 11;
    localparam int EXP_LAT  = (1 + CORE_LAT + 1 + NORMAL_LAT) - FLUSH_AT;
    @(negedge clk);
    req = 1'b1; funct3 = 3'd0; rs1 = $urandom(); rs2 = $urandom();
    early = 0;
    for (int k = 1; k <= FLUSH_AT; k++) begin
      @(negedge clk); #1;
      if (done) early++;
    end
    flush = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    lat = -1; serr = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      if (done) begin lat = k; break; end
      if (!stall) serr++;
    end
    vectors++; if (early != 0) begin errors++; $display("FAIL flush_early_done got %0d want 0", early); end
    vectors++; if (lat != EXP_LAT) begin errors++; $display("FAIL flush_new_latency got %0d want %0d", lat, EXP_LAT); end
    vectors++; if (result !== 32'd12) begin errors++; $display("FAIL flush_new_result got %h want 0000000c", result); end
    vectors++; if (serr != 0) begin errors++; $display("FAIL flush_stall got %0d bad cycles want 0", serr); end
    req = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat, serr, vc;
    @(negedge clk);
    req = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7;
    repeat (15) @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    #1;
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %0b want 0", done); end
    vectors++; if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd5, 32'd9, 32'd3, res, lat, serr, vc);
    vectors++; if (res !== 32'd3) begin errors++; $display("FAIL rstmid_divu_result got %h want 3", res); end
    vectors++; if (lat != NORMAL_LAT) begin errors++; $display("FAIL rstmid_divu_latency got %0d want %0d", lat, NORMAL_LAT); end
    vectors++; if (vc != 1) begin errors++; $display("FAIL rstmid_core_valid got %0d want 1", vc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_flush_wait();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
